// File: rtl/booth_control_if.sv
// Handshake bundle between the multiplier control unit and the board/datapath side.
interface booth_control_if;
   logic run;
   logic clear_load;
   logic m;
   logic shift_sig;
   logic add_sig;
   logic sub_sig;
   logic clear_A_load_B_sig;
   logic xa_clr_sig;
   logic busy;
   logic done;

   modport master (
      output run, clear_load, m,
      input  shift_sig, add_sig, sub_sig, clear_A_load_B_sig, xa_clr_sig, busy, done
   );

   modport slave (
      input  run, clear_load, m,
      output shift_sig, add_sig, sub_sig, clear_A_load_B_sig, xa_clr_sig, busy, done
   );
endinterface

// File: rtl/booth_control.sv
// Sequencer for the 8-bit signed shift-add multiplier: done 18 cycles after a run edge, no backpressure.
// Define SKIP_ZERO_ADD_EN to bypass ADD/SUB cycles whose multiplier bit is 0.
module booth_control (
   input  logic            clk,
   input  logic            reset,
   booth_control_if.slave  bus
);

`ifdef SKIP_ZERO_ADD_EN
   localparam bit SKIP_ZERO = 1'b1;
`else
   localparam bit SKIP_ZERO = 1'b0;
`endif

   typedef enum logic [2:0] {
      IDLE, LOAD, CLRXA, ADD, SHIFT, SUB, SHIFT_LAST, DONE
   } state_t;

   state_t     state;
   state_t     nxt;
   logic [2:0] cnt;
   logic [2:0] cnt_nxt;
   logic       run_q;
   logic       start;

   logic       shift_q;
   logic       add_q;
   logic       sub_q;
   logic       load_q;
   logic       xa_q;
   logic       busy_q;
   logic       done_q;

   assign start = bus.run & ~run_q;

   always_comb begin
      nxt     = state;
      cnt_nxt = cnt;
      case (state)
         IDLE: begin
            // clear_load wins; a simultaneous start edge is simply lost
            if (bus.clear_load)
               nxt = LOAD;
            else if (start)
               nxt = CLRXA;
         end
         LOAD:  nxt = IDLE;
         CLRXA: begin
            cnt_nxt = 3'd0;
            nxt     = (bus.m || !SKIP_ZERO) ? ADD : SHIFT;
         end
         ADD:   nxt = SHIFT;
         SHIFT: begin
            if (cnt == 3'd6) begin
               nxt = (bus.m || !SKIP_ZERO) ? SUB : SHIFT_LAST;
            end else begin
               cnt_nxt = cnt + 3'd1;
               nxt     = (bus.m || !SKIP_ZERO) ? ADD : SHIFT;
            end
         end
         SUB:        nxt = SHIFT_LAST;
         SHIFT_LAST: nxt = DONE;
         DONE: begin
            if (!bus.run)
               nxt = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   // Output flags are decoded from the next state so they align with the state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= 3'd0;
         run_q   <= 1'b1;
         shift_q <= 1'b0;
         add_q   <= 1'b0;
         sub_q   <= 1'b0;
         load_q  <= 1'b0;
         xa_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state   <= nxt;
         cnt     <= cnt_nxt;
         run_q   <= bus.run;
         shift_q <= (nxt == SHIFT) || (nxt == SHIFT_LAST);
         add_q   <= (nxt == ADD);
         sub_q   <= (nxt == SUB);
         load_q  <= (nxt == LOAD);
         xa_q    <= (nxt == CLRXA);
         busy_q  <= (nxt == CLRXA) || (nxt == ADD) || (nxt == SHIFT) ||
                    (nxt == SUB)   || (nxt == SHIFT_LAST);
         done_q  <= (nxt == DONE);
      end
   end

   assign bus.shift_sig          = shift_q;
   assign bus.add_sig            = add_q & bus.m;
   assign bus.sub_sig            = sub_q & bus.m;
   assign bus.clear_A_load_B_sig = load_q;
   assign bus.xa_clr_sig         = xa_q;
   assign bus.busy               = busy_q;
   assign bus.done               = done_q;

endmodule

// File: tb/tb_booth_control.sv
// Bench for booth_control: per-cycle scoreboard of expected strobes plus table-driven result checks.
module tb_booth_control;

`ifdef SKIP_ZERO_ADD_EN
   localparam bit SKIP_ZERO = 1'b1;
`else
   localparam bit SKIP_ZERO = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;

   booth_control_if bus ();

   booth_control dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] pat;
      logic [7:0] add_mask;
      logic       sub_exp;
      int         busy_len;
   } vec_t;

   // exp bit order: {shift, add, sub, load, xa, busy, done}
   typedef struct {
      logic       m;
      logic [6:0] exp;
   } cyc_t;

   cyc_t sb[$];
   vec_t vt[5];
   int   ncmp  = 0;
   int   nfail = 0;

   function automatic logic [6:0] outs();
      return {bus.shift_sig, bus.add_sig, bus.sub_sig, bus.clear_A_load_B_sig,
              bus.xa_clr_sig, bus.busy, bus.done};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic mv, input logic [6:0] e);
      cyc_t c;
      c.m   = mv;
      c.exp = e;
      sb.push_back(c);
   endtask

   // Expected cycle sequence after the start edge, straight from the step list.
   task automatic build_seq(input logic [7:0] pat);
      push(pat[0], 7'b0000110);
      for (int k = 0; k < 8; k++) begin
         if (!SKIP_ZERO || pat[k])
            push(pat[k], {1'b0, (k < 7) && pat[k], (k == 7) && pat[k], 2'b00, 1'b1, 1'b0});
         push((k < 7) ? pat[k+1] : 1'b0, 7'b1000010);
      end
      push(1'b0, 7'b0000001);
   endtask

   task automatic run_mult(input vec_t v);
      cyc_t       e;
      int         shifts   = 0;
      int         busy_cnt = 0;
      int         lat      = 0;
      bit         got_done = 0;
      logic [7:0] amask    = 8'h00;
      logic       subseen  = 1'b0;
      build_seq(v.pat);
      @(negedge clk);
      bus.m   = 1'b0;
      bus.run = 1'b1;
      @(posedge clk);
      while (sb.size() > 0) begin
         #1;
         e     = sb.pop_front();
         bus.m = e.m;
         @(negedge clk);
         lat++;
         check("cycle_outputs", {25'd0, outs()}, {25'd0, e.exp});
         check("onehot", ($countones({bus.shift_sig, bus.add_sig, bus.sub_sig,
                bus.clear_A_load_B_sig, bus.xa_clr_sig}) <= 1) ? 32'd1 : 32'd0, 32'd1);
         if (bus.add_sig && shifts < 8) amask[shifts] = 1'b1;
         if (bus.sub_sig) subseen = 1'b1;
         if (bus.shift_sig) shifts++;
         if (bus.busy) busy_cnt++;
         if (bus.done && !got_done) begin
            got_done = 1;
            check("done_latency", lat, v.busy_len + 1);
         end
         @(posedge clk);
      end
      check("add_mask", {24'd0, amask}, {24'd0, v.add_mask});
      check("sub_seen", {31'd0, subseen}, {31'd0, v.sub_exp});
      check("busy_len", busy_cnt, v.busy_len);
      check("shift_count", shifts, 8);
      check("done_seen", {31'd0, got_done}, 32'd1);
   endtask

   task automatic release_run();
      @(negedge clk);
      bus.run = 1'b0;
      @(negedge clk);
      check("release_idle", {25'd0, outs()}, 32'd0);
   endtask

   initial begin
      int loads;
      int busy_seen;
      int shifts;
      bit bad;

      vt[0] = '{8'hFF, 8'h7F, 1'b1, 17};
      vt[1] = '{8'h00, 8'h00, 1'b0, SKIP_ZERO ? 9 : 17};
      vt[2] = '{8'hCD, 8'h4D, 1'b1, SKIP_ZERO ? 14 : 17};
      vt[3] = '{8'h80, 8'h00, 1'b1, SKIP_ZERO ? 10 : 17};
      vt[4] = '{8'h01, 8'h01, 1'b0, SKIP_ZERO ? 10 : 17};

      reset          = 1'b1;
      bus.run        = 1'b1;
      bus.clear_load = 1'b0;
      bus.m          = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_outputs", {25'd0, outs()}, 32'd0);
      reset = 1'b0;
      busy_seen = 0;
      repeat (5) begin
         @(negedge clk);
         if (bus.busy || bus.xa_clr_sig) busy_seen++;
      end
      check("run_held_through_reset", busy_seen, 0);
      release_run();

      for (int i = 0; i < 5; i++) begin
         run_mult(vt[i]);
         if (i == 0) begin
            bad = 0;
            for (int c = 0; c < 50; c++) begin
               @(negedge clk);
               bus.clear_load = (c == 10);
               if (!bus.done || bus.busy || bus.clear_A_load_B_sig) bad = 1;
            end
            bus.clear_load = 1'b0;
            check("done_hold", {31'd0, bad}, 32'd0);
         end
         release_run();
      end

      // clear_load and a run edge together: load only
      @(negedge clk);
      bus.clear_load = 1'b1;
      bus.run        = 1'b1;
      loads     = 0;
      busy_seen = 0;
      repeat (6) begin
         @(negedge clk);
         bus.clear_load = 1'b0;
         if (bus.clear_A_load_B_sig) loads++;
         if (bus.busy) busy_seen++;
      end
      check("load_pulses", loads, 1);
      check("load_no_busy", busy_seen, 0);
      release_run();

      // reset during the 4th shift
      @(negedge clk);
      bus.m   = 1'b1;
      bus.run = 1'b1;
      shifts  = 0;
      for (int c = 0; c < 40 && shifts < 4; c++) begin
         @(negedge clk);
         if (bus.shift_sig) shifts++;
      end
      check("reached_4th_shift", shifts, 4);
      reset = 1'b1;
      #1;
      check("async_reset_outputs", {25'd0, outs()}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      busy_seen = 0;
      repeat (5) begin
         @(negedge clk);
         if (bus.busy || bus.xa_clr_sig) busy_seen++;
      end
      check("no_start_after_reset", busy_seen, 0);
      release_run();
      run_mult(vt[2]);
      release_run();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

endmodule
